// File: rtl/ws2812_frame_buffer.sv
// ============================================================================
// Module   : ws2812_frame_buffer
// Brief    : Double-buffered RGB pixel store for a WS2812 serializer; banks
//            swap only at a frame start. Optional gamma output stage is
//            enabled by defining WS2812_FRAME_BUFFER_GAMMA_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_frame_buffer #(
    parameter int LED_COUNT  = 480,
    parameter int FIRST_ADDR = LED_COUNT - 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [8:0]  wr_addr_i,
    input  logic [23:0] wr_data_i,
    input  logic        commit_i,
    output logic        commit_pending_o,
    output logic        swap_o,
    output logic        wr_err_o,
    input  logic [8:0]  rd_addr_i,
    output logic [7:0]  r_o,
    output logic [7:0]  g_o,
    output logic [7:0]  b_o
);

    localparam logic [9:0] c_led_count  = 10'(LED_COUNT);
    localparam logic [8:0] c_first_addr = 9'(FIRST_ADDR);

    logic [23:0] r_bank0 [LED_COUNT];
    logic [23:0] r_bank1 [LED_COUNT];

    logic        r_disp_sel;
    logic        r_commit_pending;
    logic        r_swap;
    logic        r_wr_err;
    logic [8:0]  r_rd_q;
    logic [23:0] r_pix;

    logic        w_wr_fire;
    logic        w_wr_in_range;
    logic        w_rd_in_range;
    logic        w_frame_start;
    logic        w_do_swap;
    logic        w_front_sel;
    logic [23:0] w_rd_raw;

    assign wr_ready_o    = ~r_commit_pending & ~rst_i;
    assign w_wr_fire     = wr_valid_i & wr_ready_o;
    assign w_wr_in_range = {1'b0, wr_addr_i} < c_led_count;
    assign w_rd_in_range = {1'b0, rd_addr_i} < c_led_count;

    assign w_frame_start = (rd_addr_i != r_rd_q) && (rd_addr_i == c_first_addr);
    assign w_do_swap     = w_frame_start & r_commit_pending;
    // The read sampled on the swap edge must already see the new front bank.
    assign w_front_sel   = r_disp_sel ^ w_do_swap;

    assign w_rd_raw = !w_rd_in_range ? 24'h000000 :
                      (w_front_sel ? r_bank1[rd_addr_i] : r_bank0[rd_addr_i]);

    // Pixel storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_fire && w_wr_in_range) begin
            if (r_disp_sel) begin
                r_bank0[wr_addr_i] <= wr_data_i;
            end else begin
                r_bank1[wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_disp_sel       <= 1'b0;
            r_commit_pending <= 1'b0;
            r_swap           <= 1'b0;
            r_wr_err         <= 1'b0;
            r_rd_q           <= c_first_addr;
            r_pix            <= 24'h000000;
        end else begin
            r_rd_q <= rd_addr_i;
            r_swap <= w_do_swap;
            r_pix  <= w_rd_raw;
            if (w_do_swap) begin
                r_disp_sel       <= ~r_disp_sel;
                r_commit_pending <= 1'b0;
            end else if (commit_i) begin
                r_commit_pending <= 1'b1;
            end
            if (w_wr_fire && !w_wr_in_range) begin
                r_wr_err <= 1'b1;
            end
        end
    end

    assign commit_pending_o = r_commit_pending;
    assign swap_o           = r_swap;
    assign wr_err_o         = r_wr_err;

`ifdef WS2812_FRAME_BUFFER_GAMMA_EN
    // Table entry: round(x^2 * fifthroot(x/255)*255 / 255^2), i.e. (x/255)^2.2*255.
    function automatic logic [7:0] f_gamma(input int x);
        longint v_target;
        longint v_lo;
        longint v_hi;
        longint v_mid;
        longint v_y;
        v_target = longint'(x) * 64'sd4228250625;
        v_lo     = 0;
        v_hi     = 255;
        for (int i = 0; i < 9; i++) begin
            v_mid = (v_lo + v_hi + 1) / 2;
            if (v_lo < v_hi) begin
                if (v_mid * v_mid * v_mid * v_mid * v_mid <= v_target) begin
                    v_lo = v_mid;
                end else begin
                    v_hi = v_mid - 1;
                end
            end
        end
        v_y = (longint'(x) * longint'(x) * v_lo + 64'sd32512) / 64'sd65025;
        return v_y[7:0];
    endfunction

    logic [7:0]  w_gamma_rom [256];
    logic [23:0] r_pix_gamma;

    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_gamma_rom
            assign w_gamma_rom[gi] = f_gamma(gi);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pix_gamma <= 24'h000000;
        end else begin
            r_pix_gamma <= {w_gamma_rom[r_pix[23:16]],
                            w_gamma_rom[r_pix[15:8]],
                            w_gamma_rom[r_pix[7:0]]};
        end
    end

    assign r_o = r_pix_gamma[23:16];
    assign g_o = r_pix_gamma[15:8];
    assign b_o = r_pix_gamma[7:0];
`else
    assign r_o = r_pix[23:16];
    assign g_o = r_pix[15:8];
    assign b_o = r_pix[7:0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_ws2812_frame_buffer.sv
// ============================================================================
// Module   : tb_ws2812_frame_buffer
// Brief    : Self-checking bench for ws2812_frame_buffer (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ws2812_frame_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [8:0]  wr_addr_i;
    logic [23:0] wr_data_i;
    logic        commit_i;
    logic        commit_pending_o;
    logic        swap_o;
    logic        wr_err_o;
    logic [8:0]  rd_addr_i;
    logic [7:0]  r_o;
    logic [7:0]  g_o;
    logic [7:0]  b_o;

    int n_tests = 0;
    int n_fail  = 0;

    ws2812_frame_buffer dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .wr_valid_i       (wr_valid_i),
        .wr_ready_o       (wr_ready_o),
        .wr_addr_i        (wr_addr_i),
        .wr_data_i        (wr_data_i),
        .commit_i         (commit_i),
        .commit_pending_o (commit_pending_o),
        .swap_o           (swap_o),
        .wr_err_o         (wr_err_o),
        .rd_addr_i        (rd_addr_i),
        .r_o              (r_o),
        .g_o              (g_o),
        .b_o              (b_o)
    );

    always #5 clk_i = ~clk_i;

    // Spec-level model: two pixel arrays with a "written" flag, a displayed
    // bank index, a pending-commit flag and the last serializer address.
    logic [23:0] m_mem   [2][480];
    bit          m_known [2][480];
    bit          m_disp;
    bit          m_pend;
    bit          m_swap;
    bit          m_err;
    bit          m_live = 1'b0;
    bit          m_rgb_known;
    logic [23:0] m_rgb;
    int          m_last_rd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic model_step();
        bit frame_start;
        bit do_swap;
        int wa;
        int ra;
        wa = int'(wr_addr_i);
        ra = int'(rd_addr_i);
        if (rst_i) begin
            m_disp      = 1'b0;
            m_pend      = 1'b0;
            m_swap      = 1'b0;
            m_err       = 1'b0;
            m_rgb       = 24'h0;
            m_rgb_known = 1'b1;
            m_last_rd   = 479;
            m_live      = 1'b1;
        end else if (m_live) begin
            frame_start = (ra != m_last_rd) && (ra == 479);
            do_swap     = frame_start && m_pend;
            if (wr_valid_i && !m_pend) begin
                if (wa < 480) begin
                    m_mem[int'(!m_disp)][wa]   = wr_data_i;
                    m_known[int'(!m_disp)][wa] = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (do_swap) m_disp = !m_disp;
            if (ra < 480) begin
                m_rgb       = m_mem[int'(m_disp)][ra];
                m_rgb_known = m_known[int'(m_disp)][ra];
            end else begin
                m_rgb       = 24'h0;
                m_rgb_known = 1'b1;
            end
            if (do_swap) m_pend = 1'b0;
            else if (commit_i) m_pend = 1'b1;
            m_swap    = do_swap;
            m_last_rd = ra;
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        model_step();
    end

    initial forever begin
        @(negedge clk_i);
        if (m_live) begin
            check("cmp_wr_ready", 32'(wr_ready_o), 32'(!m_pend && !rst_i));
            check("cmp_pending", 32'(commit_pending_o), 32'(m_pend));
            check("cmp_swap", 32'(swap_o), 32'(m_swap));
            check("cmp_wr_err", 32'(wr_err_o), 32'(m_err));
            if (m_rgb_known) check("cmp_rgb", 32'({r_o, g_o, b_o}), 32'(m_rgb));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rgb();
        return 32'({r_o, g_o, b_o});
    endfunction

    task automatic put(input int a, input logic [23:0] d);
        wr_valid_i = 1'b1;
        wr_addr_i  = 9'(a);
        wr_data_i  = d;
        tick();
        wr_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; wr_valid_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        commit_i = 1'b0; rd_addr_i = 9'd5;
        repeat (3) tick();
        check("rst_wr_ready", 32'(wr_ready_o), 32'd0);
        check("rst_pending", 32'(commit_pending_o), 32'd0);
        check("rst_swap", 32'(swap_o), 32'd0);
        check("rst_wr_err", 32'(wr_err_o), 32'd0);
        check("rst_rgb", rgb(), 32'h0);

        rst_i = 1'b0;
        tick();
        check("ready_after_rst", 32'(wr_ready_o), 32'd1);

        // Fill back bank, last write shares the cycle with commit.
        put(0, 24'hFF0000);
        put(1, 24'h00FF00);
        put(3, 24'h111111);
        wr_valid_i = 1'b1; wr_addr_i = 9'd2; wr_data_i = 24'h0000FF; commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        check("pending_set", 32'(commit_pending_o), 32'd1);
        wr_addr_i = 9'd3; wr_data_i = 24'hAAAAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ready", 32'(wr_ready_o), 32'd0);
        end
        wr_valid_i = 1'b0;

        rd_addr_i = 9'd479;
        tick();
        check("swap_pulse", 32'(swap_o), 32'd1);
        check("pending_clear", 32'(commit_pending_o), 32'd0);
        check("ready_after_swap", 32'(wr_ready_o), 32'd1);
        rd_addr_i = 9'd0; tick();
        check("swap_single", 32'(swap_o), 32'd0);
        check("rd_pix0", rgb(), 32'hFF0000);
        rd_addr_i = 9'd1; tick();
        check("rd_pix1", rgb(), 32'h00FF00);
        rd_addr_i = 9'd2; tick();
        check("rd_pix2_commit_cycle", rgb(), 32'h0000FF);
        rd_addr_i = 9'd3; tick();
        check("rd_pix3_no_stalled_write", rgb(), 32'h111111);

        // Out-of-range write and read.
        put(480, 24'h123456);
        check("wr_err_set", 32'(wr_err_o), 32'd1);
        rd_addr_i = 9'd480; tick();
        check("rd_oor_zero", rgb(), 32'h0);
        rd_addr_i = 9'd511; tick();
        check("wr_err_sticky", 32'(wr_err_o), 32'd1);
        check("rd_oor_511_zero", rgb(), 32'h0);

        // Commit coinciding with a frame start waits for the next one.
        put(0, 24'h0A0B0C);
        rd_addr_i = 9'd0; tick();
        commit_i = 1'b1; rd_addr_i = 9'd479;
        tick();
        commit_i = 1'b0;
        check("no_swap_same_cycle", 32'(swap_o), 32'd0);
        check("pending_after_late", 32'(commit_pending_o), 32'd1);
        tick();
        check("no_swap_held_addr", 32'(swap_o), 32'd0);
        rd_addr_i = 9'd0; tick();
        rd_addr_i = 9'd479; tick();
        check("swap_next_start", 32'(swap_o), 32'd1);
        rd_addr_i = 9'd0; tick();
        check("rd_bank0_pix0", rgb(), 32'h0A0B0C);

        // One more frame so bank 1 is displayed before the mid-frame reset.
        put(0, 24'h555555);
        commit_i = 1'b1; tick(); commit_i = 1'b0;
        rd_addr_i = 9'd479; tick();
        check("swap_third", 32'(swap_o), 32'd1);
        rd_addr_i = 9'd0; tick();
        check("rd_bank1_pix0", rgb(), 32'h555555);

        put(0, 24'h777777);
        commit_i = 1'b1; tick(); commit_i = 1'b0;
        check("pending_before_rst", 32'(commit_pending_o), 32'd1);
        rst_i = 1'b1;
        tick();
        check("midrst_pending", 32'(commit_pending_o), 32'd0);
        check("midrst_rgb", rgb(), 32'h0);
        check("midrst_wr_err", 32'(wr_err_o), 32'd0);
        check("midrst_ready", 32'(wr_ready_o), 32'd0);
        rst_i = 1'b0;
        tick();
        rd_addr_i = 9'd479; tick();
        check("no_swap_after_rst", 32'(swap_o), 32'd0);
        rd_addr_i = 9'd0; tick();
        check("rd_disp0_after_rst", rgb(), 32'h777777);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ws2812_frame_buffer.md
Name: ws2812_frame_buffer

Overview:
Double-buffered pixel store that feeds the WS2812 strip serializer.
- Host side writes 24-bit RGB pixels into the back bank through a valid/ready port.
- Serializer side presents a pixel address and receives R/G/B from the front bank.
- Bank swap happens only at a frame boundary, so the strip never shows a torn frame.

Parameters:
- LED_COUNT, 480: pixels per bank; legal addresses are 0..LED_COUNT-1; must be 1..512.
- FIRST_ADDR, LED_COUNT-1: read address that marks the first pixel of a frame; used as the swap point.

Ports:
- clk_i  in  1  system clock (50 MHz).
- rst_i  in  1  synchronous, active-high reset.
- wr_valid_i  in  1  host write request.
- wr_ready_o  out  1  write accepted this cycle when wr_valid_i is also high.
- wr_addr_i  in  9  pixel index to write.
- wr_data_i  in  24  pixel value {r[23:16], g[15:8], b[7:0]}.
- commit_i  in  1  single-cycle pulse: back bank complete, request a swap.
- commit_pending_o  out  1  a swap is requested and not yet performed.
- swap_o  out  1  single-cycle pulse on the cycle the banks swap.
- wr_err_o  out  1  sticky flag: an out-of-range write was accepted.
- rd_addr_i  in  9  pixel address from the serializer.
- r_o  out  8  red of the addressed front-bank pixel.
- g_o  out  8  green of the addressed front-bank pixel.
- b_o  out  8  blue of the addressed front-bank pixel.

Behaviour:
- Storage: two banks of LED_COUNT x 24 bits.
  - front = bank[disp_sel]; back = bank[~disp_sel].
  - Contents are not cleared by reset.
- Reset values: disp_sel=0; wr_ready_o=0 while rst_i is high; commit_pending_o=0, swap_o=0, wr_err_o=0; r_o/g_o/b_o=0.
- First cycle after reset release: wr_ready_o=1.
- Write handshake:
  - A transfer occurs on a rising edge with wr_valid_i & wr_ready_o.
  - The data lands in the back bank at wr_addr_i.
  - wr_ready_o = ~commit_pending_o & ~rst_i; writes stall while a swap is pending.
- Out-of-range write (wr_addr_i >= LED_COUNT): handshake completes, data is discarded, wr_err_o is set.
  - wr_err_o clears only on reset.
- Commit:
  - commit_i while commit_pending_o=0: commit_pending_o goes to 1 next cycle.
  - commit_i while commit_pending_o=1: ignored.
  - A write and a commit in the same cycle are legal; that write belongs to the committed frame.
- Swap event:
  - rd_q is the registered rd_addr_i.
  - A frame start is detected when rd_addr_i != rd_q and rd_addr_i == FIRST_ADDR.
  - If commit_pending_o=1 at that edge: disp_sel toggles, commit_pending_o clears, and swap_o pulses high for one cycle.
  - The read issued on that same edge already uses the new front bank.
  - A commit_i arriving in the same cycle as a frame start does not swap on that start; it waits for the next one.
- Frame-start detection after reset: rd_q resets to FIRST_ADDR, so no frame start is detected from reset alone.
- Read path:
  - r_o/g_o/b_o are registered; read latency is 1 cycle from a rd_addr_i change.
  - This is well inside the serializer's 63-cycle first-bit window.
  - rd_addr_i >= LED_COUNT reads as 24'h000000.
- Read and write never collide, because they target different banks.
- Reset mid-frame: disp_sel returns to 0, a pending commit is lost, and the host must rewrite and recommit.

Optional Feature:
- Macro: WS2812_FRAME_BUFFER_GAMMA_EN.
- Defined:
  - Each colour passes through a shared 256x8 gamma ROM, approximately (x/255)^2.2*255 rounded.
  - Required points: 0->0, 255->255, 128->56.
  - Adds one register stage: read latency is 2 cycles.
  - The out-of-range zero is applied before the ROM, and the ROM maps 0->0.
- Undefined: raw stored values, 1-cycle latency, no ROM inferred.

Test Plan:
- Reset, then write 0:24'hFF0000 and 1:24'h00FF00, then commit_i. Step rd_addr_i 5->479 (FIRST_ADDR) -> swap_o pulses once, commit_pending_o goes 1->0. rd_addr_i=0 gives r/g/b=FF/00/00 one cycle later; rd_addr_i=1 gives 00/FF/00.
- After commit_i, hold wr_valid_i=1 -> wr_ready_o=0 until the swap cycle, then 1. No write lands in the bank being displayed.
- Write wr_addr_i=480 with data 24'h123456 -> handshake completes, wr_err_o=1 and stays 1. rd_addr_i=480 reads 000000.
- commit_i in the same cycle rd_addr_i changes to 479 -> no swap_o then. The next 0->479 transition produces swap_o.
- Assert rst_i while commit_pending_o=1 -> all outputs return to reset values and disp_sel=0. Stepping rd_addr_i to 479 produces no swap.
- With WS2812_FRAME_BUFFER_GAMMA_EN: pixel 24'h80FF00 -> r/g/b=56/255/0 two cycles after the address change.
